control_nivel_comida: RTL and testbench
=======================================

# control_nivel_comida

Producer side of the pet's food-level interface. Generates the 2-bit food level consumed by the pet state machine: the level decays over time, refills while the pet is eating and the food button is held, and freezes in test mode. Also debounces the raw food and test buttons to provide clean levels for the state machine and test-step logic.

## Interface
- `DECAY_TICKS`, default 250_000_000: clock cycles per one-step level decrement (5 s at 50 MHz); must be ≥ 2.
- `FEED_TICKS`, default 50_000_000: clock cycles of held feeding per one-step level increment; must be ≥ 2.
- `DEBOUNCE_TICKS`, default 1_000_000: consecutive stable cycles required before a debounced output changes; must be ≥ 2.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `Boton_Comida_raw` in 1: raw food button, active-high, asynchronous to `clk`.
- `Boton_Test_raw` in 1: raw test button, active-high, asynchronous to `clk`.
- `Activo_Comida` in 1: from the pet state machine; 0 means the pet is in the eating state.
- `Senal_MTest` in 1: test mode; 1 freezes the level.
- `Nivel_Comida` out 2: food level 0..3; 3 means full.
- `Boton_Comida` out 1: debounced food button.
- `Senal_Test_fil` out 1: debounced test button.

## Operation
- Reset values (next edge with `reset`=1; this also applies mid-operation): `Nivel_Comida`=3, `Boton_Comida`=0, `Senal_Test_fil`=0, all counters 0, state NORMAL.
- **Debounce** (per channel):
  - 2-FF synchronizer feeds a stable-counter.
  - The counter increments on every cycle where the synchronized value differs from the output. Any cycle of equality clears it.
  - When the counter is DEBOUNCE_TICKS-1 and the values still differ, the output takes the synchronized value and the counter clears.
- **Level FSM** (registered; evaluated every cycle in priority order):
  - CONGELADO if `Senal_MTest`=1.
  - Else ALIMENTANDO if `Activo_Comida`=0 and `Boton_Comida`=1.
  - Else NORMAL.
- **NORMAL**:
  - The decay timer counts 0..DECAY_TICKS-1 and wraps.
  - On the wrap cycle, `Nivel_Comida` decrements, saturating at 0 (the timer still wraps).
  - The feed timer is held at 0.
- **ALIMENTANDO**:
  - The feed timer counts 0..FEED_TICKS-1.
  - On the wrap cycle, `Nivel_Comida` increments, saturating at 3.
  - The decay timer is held at 0.
- **CONGELADO**: both timers are held at 0 and `Nivel_Comida` is unchanged.
- **Timer restarts**: leaving any state clears both timers, so partial intervals are discarded. Decrement and increment can never occur in the same cycle.
- **Arithmetic**: each timer's width is $clog2 of its tick parameter. The level uses 2-bit saturating arithmetic with no wrap-around.

## Timing
- **Debounce latency**: after a clean raw transition at edge 0, the debounced output changes at edge DEBOUNCE_TICKS+2 (2 synchronizer stages plus DEBOUNCE_TICKS stable cycles).
- **Bounce rejection**: a raw pulse shorter than DEBOUNCE_TICKS cycles after synchronization never reaches the output.
- **State latency**: the FSM state updates 1 edge after its inputs change.
- **First decrement**: DECAY_TICKS edges after entering NORMAL, including after reset release.
- **First increment**: FEED_TICKS edges after entering ALIMENTANDO.
- **Decay after test mode**: `Senal_MTest` falling → NORMAL on the next edge → first decrement DECAY_TICKS edges later (DECAY_TICKS+1 edges after the fall).
- All outputs are registered; there is no combinational path from input to output.

## Structure
- The shared package holds:
  - state encoding `NORMAL`=2'd0, `ALIMENTANDO`=2'd1, `CONGELADO`=2'd2;
  - `NIVEL_MAX`=2'd3 and `NIVEL_MIN`=2'd0.
- One sub-module, `antirrebote`, parameterized by DEBOUNCE_TICKS, contains the synchronizer and stable-counter. It is instantiated twice, once for food and once for test.
- The level FSM, both timers and the saturating level register live in the top module.

## Test plan
All scenarios use DECAY_TICKS=8, FEED_TICKS=4, DEBOUNCE_TICKS=3.
- **Decay and saturation**: release reset with all inputs 0 → `Nivel_Comida` reads 3, then 2 at edge 8, 1 at edge 16, 0 at edge 24, and stays 0 at edge 32 and beyond.
- **Bounce rejection**: toggle `Boton_Comida_raw` every cycle for 10 cycles, then hold it at 1 → `Boton_Comida` stays 0 throughout the bounce and rises exactly 5 edges after the last raw transition. Repeat on `Boton_Test_raw` → same behaviour on `Senal_Test_fil`.
- **Feeding**: start at level 0, set `Activo_Comida`=0 and hold `Boton_Comida`=1 → level increments every 4 cycles after entering ALIMENTANDO (1, 2, 3) and then saturates at 3. Releasing the button returns to NORMAL and decay restarts from timer 0.
- **Button without eating**: hold `Boton_Comida`=1 with `Activo_Comida`=1 → no increments; decay continues every 8 cycles.
- **Test freeze**: hold `Senal_MTest`=1 for 20 cycles at level 2 → level stays 2. Drop `Senal_MTest` → level reads 1 exactly 9 edges later.
- **Reset mid-operation**: assert `reset` for 1 cycle while in ALIMENTANDO at level 1 with the timer at 2 → next edge: level 3, debounced outputs 0, state NORMAL, timers 0.

Source files
------------

// File: rtl/control_nivel_comida_pkg.sv
// Shared types and constants for the food-level producer: level FSM encoding
// and the saturating 2-bit level helpers.
package control_nivel_comida_pkg;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        ALIMENTANDO = 2'd1,
        CONGELADO   = 2'd2
    } estado_t;

    localparam logic [1:0] NIVEL_MAX = 2'd3;
    localparam logic [1:0] NIVEL_MIN = 2'd0;

    function automatic logic [1:0] nivel_sube(input logic [1:0] nivel);
        return (nivel == NIVEL_MAX) ? NIVEL_MAX : nivel + 2'd1;
    endfunction

    function automatic logic [1:0] nivel_baja(input logic [1:0] nivel);
        return (nivel == NIVEL_MIN) ? NIVEL_MIN : nivel - 2'd1;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Button debouncer: 2-FF synchronizer followed by a stable-run counter that
// only lets a level through after DEBOUNCE_TICKS consecutive differing cycles.
module antirrebote
    import control_nivel_comida_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic salida
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             salida_q;
    logic             salida_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            salida_q <= 1'b0;
        end else begin
            sync1_q  <= entrada;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            salida_q <= salida_d;
        end
    end

    // Any cycle where the synchronized input agrees with the output restarts the run.
    always_comb begin
        cnt_d    = '0;
        salida_d = salida_q;
        if (sync2_q != salida_q) begin
            if (cnt_q == CNT_LAST) begin
                salida_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign salida = salida_q;

endmodule

// File: rtl/control_nivel_comida.sv
// Food-level producer: debounced buttons plus a level register that decays in
// NORMAL, refills in ALIMENTANDO and holds in CONGELADO.
module control_nivel_comida
    import control_nivel_comida_pkg::*;
#(
    parameter int unsigned DECAY_TICKS    = 250_000_000,
    parameter int unsigned FEED_TICKS     = 50_000_000,
    parameter int unsigned DEBOUNCE_TICKS = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Boton_Comida_raw,
    input  logic       Boton_Test_raw,
    input  logic       Activo_Comida,
    input  logic       Senal_MTest,
    output logic [1:0] Nivel_Comida,
    output logic       Boton_Comida,
    output logic       Senal_Test_fil
);

    localparam int unsigned DECAY_W = $clog2(DECAY_TICKS);
    localparam int unsigned FEED_W  = $clog2(FEED_TICKS);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_TICKS - 1);
    localparam logic [FEED_W-1:0]  FEED_LAST  = FEED_W'(FEED_TICKS - 1);

    estado_t             estado_q;
    estado_t             estado_d;
    logic [DECAY_W-1:0]  decay_q;
    logic [DECAY_W-1:0]  decay_d;
    logic [FEED_W-1:0]   feed_q;
    logic [FEED_W-1:0]   feed_d;
    logic [1:0]          nivel_q;
    logic [1:0]          nivel_d;

    antirrebote #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_antirrebote_comida (
        .clk    (clk),
        .reset  (reset),
        .entrada(Boton_Comida_raw),
        .salida (Boton_Comida)
    );

    antirrebote #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_antirrebote_test (
        .clk    (clk),
        .reset  (reset),
        .entrada(Boton_Test_raw),
        .salida (Senal_Test_fil)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= NORMAL;
            decay_q  <= '0;
            feed_q   <= '0;
            nivel_q  <= NIVEL_MAX;
        end else begin
            estado_q <= estado_d;
            decay_q  <= decay_d;
            feed_q   <= feed_d;
            nivel_q  <= nivel_d;
        end
    end

    always_comb begin
        estado_d = NORMAL;
        if (Senal_MTest) begin
            estado_d = CONGELADO;
        end else if (!Activo_Comida && Boton_Comida) begin
            estado_d = ALIMENTANDO;
        end
    end

    always_comb begin
        decay_d = '0;
        feed_d  = '0;
        nivel_d = nivel_q;
        unique case (estado_q)
            NORMAL: begin
                if (decay_q == DECAY_LAST) begin
                    nivel_d = nivel_baja(nivel_q);
                end else begin
                    decay_d = decay_q + 1'b1;
                end
            end
            ALIMENTANDO: begin
                if (feed_q == FEED_LAST) begin
                    nivel_d = nivel_sube(nivel_q);
                end else begin
                    feed_d = feed_q + 1'b1;
                end
            end
            CONGELADO: begin
            end
            default: begin
            end
        endcase
        // A state change discards any partial interval in either timer.
        if (estado_d != estado_q) begin
            decay_d = '0;
            feed_d  = '0;
        end
    end

    assign Nivel_Comida = nivel_q;

endmodule

// File: tb/tb_control_nivel_comida.sv
// Directed bench for control_nivel_comida with a cycle-level behavioural model
// checked every cycle, plus hand-computed expectations from the scenarios.
module tb_control_nivel_comida;

    localparam int unsigned DECAY = 8;
    localparam int unsigned FEED  = 4;
    localparam int unsigned DEB   = 3;

    logic       clk;
    logic       reset;
    logic       Boton_Comida_raw;
    logic       Boton_Test_raw;
    logic       Activo_Comida;
    logic       Senal_MTest;
    logic [1:0] Nivel_Comida;
    logic       Boton_Comida;
    logic       Senal_Test_fil;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: level, mode (0 normal, 1 feeding, 2 frozen), cycles spent in mode,
    // and per-channel debounce state (0 food, 1 test).
    int m_level;
    int m_mode;
    int m_elapsed;
    int m_s1[2];
    int m_s2[2];
    int m_run[2];
    int m_out[2];

    control_nivel_comida #(
        .DECAY_TICKS   (DECAY),
        .FEED_TICKS    (FEED),
        .DEBOUNCE_TICKS(DEB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Boton_Comida_raw(Boton_Comida_raw),
        .Boton_Test_raw  (Boton_Test_raw),
        .Activo_Comida   (Activo_Comida),
        .Senal_MTest     (Senal_MTest),
        .Nivel_Comida    (Nivel_Comida),
        .Boton_Comida    (Boton_Comida),
        .Senal_Test_fil  (Senal_Test_fil)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT will sample.
    task automatic model_step();
        int raw[2];
        int next_mode;
        if (reset) begin
            m_level   = 3;
            m_mode    = 0;
            m_elapsed = 0;
            for (int c = 0; c < 2; c++) begin
                m_s1[c]  = 0;
                m_s2[c]  = 0;
                m_run[c] = 0;
                m_out[c] = 0;
            end
        end else begin
            raw[0] = int'(Boton_Comida_raw);
            raw[1] = int'(Boton_Test_raw);
            if (Senal_MTest) next_mode = 2;
            else if (!Activo_Comida && m_out[0] == 1) next_mode = 1;
            else next_mode = 0;
            if (m_mode == 0) begin
                m_elapsed++;
                if (m_elapsed % DECAY == 0 && m_level > 0) m_level--;
            end else if (m_mode == 1) begin
                m_elapsed++;
                if (m_elapsed % FEED == 0 && m_level < 3) m_level++;
            end
            if (next_mode != m_mode) begin
                m_mode    = next_mode;
                m_elapsed = 0;
            end
            for (int c = 0; c < 2; c++) begin
                if (m_s2[c] != m_out[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= DEB) begin
                        m_out[c] = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
        check("model_nivel", int'(Nivel_Comida), m_level);
        check("model_boton_comida", int'(Boton_Comida), m_out[0]);
        check("model_test_fil", int'(Senal_Test_fil), m_out[1]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        Boton_Comida_raw = 1'b0;
        Boton_Test_raw   = 1'b0;
        Activo_Comida    = 1'b0;
        Senal_MTest      = 1'b0;
        tick();
        check("reset_nivel", int'(Nivel_Comida), 3);
        check("reset_boton", int'(Boton_Comida), 0);
        check("reset_test", int'(Senal_Test_fil), 0);
        reset = 1'b0;

        // Decay from full to empty, then saturate.
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (i == 7)  check("decay_e7", int'(Nivel_Comida), 3);
            if (i == 8)  check("decay_e8", int'(Nivel_Comida), 2);
            if (i == 16) check("decay_e16", int'(Nivel_Comida), 1);
            if (i == 24) check("decay_e24", int'(Nivel_Comida), 0);
            if (i == 32) check("decay_e32", int'(Nivel_Comida), 0);
        end

        // Bounce on the test button, then clean press and release.
        for (int i = 0; i < 10; i++) begin
            Boton_Test_raw = ~Boton_Test_raw;
            tick();
            check("bounce_test", int'(Senal_Test_fil), 0);
        end
        Boton_Test_raw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) check("test_rise_e4", int'(Senal_Test_fil), 0);
            if (i == 5) check("test_rise_e5", int'(Senal_Test_fil), 1);
        end
        Boton_Test_raw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 4) check("test_fall_e4", int'(Senal_Test_fil), 1);
            if (i == 5) check("test_fall_e5", int'(Senal_Test_fil), 0);
        end

        // Bounce on the food button while eating, then hold to refill.
        for (int i = 0; i < 10; i++) begin
            Boton_Comida_raw = ~Boton_Comida_raw;
            tick();
            check("bounce_comida", int'(Boton_Comida), 0);
        end
        Boton_Comida_raw = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (i == 4)  check("comida_rise_e4", int'(Boton_Comida), 0);
            if (i == 5)  check("comida_rise_e5", int'(Boton_Comida), 1);
            if (i == 9)  check("feed_e9", int'(Nivel_Comida), 0);
            if (i == 10) check("feed_e10", int'(Nivel_Comida), 1);
            if (i == 14) check("feed_e14", int'(Nivel_Comida), 2);
            if (i == 18) check("feed_e18", int'(Nivel_Comida), 3);
            if (i == 26) check("feed_sat", int'(Nivel_Comida), 3);
        end

        // Release: back to NORMAL, decay restarts from a fresh interval.
        Boton_Comida_raw = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 5)  check("release_boton", int'(Boton_Comida), 0);
            if (i == 13) check("release_e13", int'(Nivel_Comida), 3);
            if (i == 14) check("release_e14", int'(Nivel_Comida), 2);
        end

        // Freeze at level 2, then resume decay.
        Senal_MTest = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 8)  check("freeze_e8", int'(Nivel_Comida), 2);
            if (i == 20) check("freeze_e20", int'(Nivel_Comida), 2);
        end
        Senal_MTest = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 8) check("unfreeze_e8", int'(Nivel_Comida), 2);
            if (i == 9) check("unfreeze_e9", int'(Nivel_Comida), 1);
        end

        // Button held while not eating: no refill, decay continues.
        Activo_Comida    = 1'b1;
        Boton_Comida_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5)  check("noeat_boton", int'(Boton_Comida), 1);
            if (i == 7)  check("noeat_e7", int'(Nivel_Comida), 1);
            if (i == 8)  check("noeat_e8", int'(Nivel_Comida), 0);
            if (i == 20) check("noeat_e20", int'(Nivel_Comida), 0);
        end

        // Start eating, reset with level 1 and feed timer at 2.
        Activo_Comida = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 4) check("eat_e4", int'(Nivel_Comida), 0);
            if (i == 5) check("eat_e5", int'(Nivel_Comida), 1);
        end
        reset            = 1'b1;
        Boton_Comida_raw = 1'b0;
        tick();
        check("midreset_nivel", int'(Nivel_Comida), 3);
        check("midreset_boton", int'(Boton_Comida), 0);
        check("midreset_test", int'(Senal_Test_fil), 0);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check("postreset_e7", int'(Nivel_Comida), 3);
            if (i == 8) check("postreset_e8", int'(Nivel_Comida), 2);
            if (i == 8) check("postreset_boton", int'(Boton_Comida), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
